// File: rtl/sipo_frame_ctrl_if.sv
// Handshake/bus bundle for sipo_frame_ctrl.
// master: serial source plus parallel consumer side; slave: the framing controller.
interface sipo_frame_ctrl_if #(
    parameter int unsigned WIDTH = 8
);

    logic             start;
    logic             bit_en;
    logic             data;
    logic [WIDTH-1:0] op;
    logic             op_valid;
    logic             op_ready;
    logic             busy;
    logic             overrun;
    logic             clr_ovr;
    logic             parity_err;

    modport master (
        output start,
        output bit_en,
        output data,
        output op_ready,
        output clr_ovr,
        input  op,
        input  op_valid,
        input  busy,
        input  overrun,
        input  parity_err
    );

    modport slave (
        input  start,
        input  bit_en,
        input  data,
        input  op_ready,
        input  clr_ovr,
        output op,
        output op_valid,
        output busy,
        output overrun,
        output parity_err
    );

endinterface

// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out framing controller.
// A start pulse opens a frame; each bit_en shifts one data bit in, MSB first. The finished
// word moves into a held output register (double buffered against the shift register) and is
// offered through a valid/ready handshake. A word that finishes while the output register is
// still occupied and not being drained is dropped and raises the sticky overrun flag.
// Optional feature macro: PARITY_CHECK_EN -- one extra parity bit per frame, checked against
// PARITY_ODD and reported on parity_err alongside the word.
module sipo_frame_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned PARITY_ODD = 0
) (
    input logic              clk,
    input logic              rst,
    sipo_frame_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StParity = 2'd2
    } state_e;

    // Count value at which the final data bit of a frame is being sampled.
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] op_q,    op_d;
    logic             op_valid_q, op_valid_d;
    logic             ovr_q,   ovr_d;

    logic [WIDTH-1:0] shifted;
    logic             done;
    logic [WIDTH-1:0] done_word;
    logic             load;
    logic             drop;

`ifdef PARITY_CHECK_EN
    logic             perr_q, perr_d;
    logic             done_perr;
`else
    logic             unused_parity_odd;
`endif

    assign shifted = {shreg_q[WIDTH-2:0], bus.data};

    // Frame sequencing: state, shift register and bit counter.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        done      = 1'b0;
        done_word = shreg_q;
`ifdef PARITY_CHECK_EN
        done_perr = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                // A bit_en coinciding with start belongs to no frame and is not sampled.
                if (bus.start) begin
                    state_d = StShift;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                if (bus.bit_en) begin
                    shreg_d = shifted;
                    if (cnt_q == LastCnt) begin
                        cnt_d = '0;
`ifdef PARITY_CHECK_EN
                        state_d = StParity;
`else
                        state_d   = StIdle;
                        done      = 1'b1;
                        done_word = shifted;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StParity: begin
`ifdef PARITY_CHECK_EN
                if (bus.bit_en) begin
                    state_d   = StIdle;
                    done      = 1'b1;
                    done_word = shreg_q;
                    done_perr = (^shreg_q) ^ bus.data ^ PARITY_ODD[0];
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    // Output register, handshake and overrun tracking.
    always_comb begin
        op_d       = op_q;
        op_valid_d = op_valid_q;
`ifdef PARITY_CHECK_EN
        perr_d     = perr_q;
`endif
        // The slot can take a new word if it is empty or being drained this cycle.
        load = done & (~op_valid_q | bus.op_ready);
        drop = done & op_valid_q & ~bus.op_ready;

        if (op_valid_q && bus.op_ready) begin
            op_valid_d = 1'b0;
        end
        if (load) begin
            op_d       = done_word;
            op_valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
            perr_d     = done_perr;
`endif
        end
        // A fresh drop wins over a simultaneous clear.
        ovr_d = (ovr_q & ~bus.clr_ovr) | drop;
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            cnt_q      <= '0;
            op_q       <= '0;
            op_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            op_valid_q <= op_valid_d;
            ovr_q      <= ovr_d;
        end
    end

`ifdef PARITY_CHECK_EN
    // Parity result travels with the word it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign bus.parity_err = perr_q;
`else
    assign unused_parity_odd = PARITY_ODD[0];
    assign bus.parity_err    = 1'b0;
`endif

    assign bus.op       = op_q;
    assign bus.op_valid = op_valid_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.overrun  = ovr_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: directed scenarios followed by randomized frames.
// The reference model collects sampled bits per frame, packs them into words and tracks an
// abstract one-entry output slot; completed words go onto a scoreboard queue which a separate
// monitor compares against the DUT whenever op_valid is presented.
module tb_sipo_frame_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;
`ifdef PARITY_CHECK_EN
    localparam int unsigned PODD       = 0;
    localparam int unsigned FRAME_BITS = W + 1;
`else
    localparam int unsigned FRAME_BITS = W;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sipo_frame_ctrl_if #(.WIDTH(W)) bus ();

    sipo_frame_ctrl #(
`ifdef PARITY_CHECK_EN
        .PARITY_ODD (PODD),
`endif
        .WIDTH      (W),
        .CNT_W      (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    int rdy_mode = 0;   // 0: op_ready low, 1: high, 2: random
    int clr_mode = 0;   // 0: clr_ovr low, 1: high, 2: occasional random
    bit force_ready = 1'b0;

    typedef struct packed {
        logic [W-1:0] word;
        logic         perr;
    } exp_t;

    exp_t sbq[$];
    bit   bq[$];
    bit   m_active = 1'b0;
    bit   m_full   = 1'b0;
    bit   m_ovr    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluated at each rising edge from the inputs applied for that cycle.
    initial begin
        forever begin
            bit           done;
            bit           set_ovr;
            logic [W-1:0] w;
            logic         pe;
            @(posedge clk);
            if (rst) begin
                m_active = 1'b0;
                m_full   = 1'b0;
                m_ovr    = 1'b0;
                bq.delete();
                sbq.delete();
            end else begin
                done    = 1'b0;
                set_ovr = 1'b0;
                if (m_full && bus.op_ready) m_full = 1'b0;
                if (!m_active) begin
                    if (bus.start) begin
                        m_active = 1'b1;
                        bq.delete();
                    end
                end else if (bus.bit_en) begin
                    bq.push_back(bus.data);
                    if (bq.size() == FRAME_BITS) begin
                        done     = 1'b1;
                        m_active = 1'b0;
                    end
                end
                if (done) begin
                    for (int i = 0; i < W; i++) w[W-1-i] = bq[i];
`ifdef PARITY_CHECK_EN
                    pe = (^w) ^ bq[W] ^ (PODD != 0);
`else
                    pe = 1'b0;
`endif
                    if (!m_full) begin
                        sbq.push_back('{word: w, perr: pe});
                        m_full = 1'b1;
                    end else begin
                        set_ovr = 1'b1;
                    end
                end
                m_ovr = (m_ovr && !bus.clr_ovr) || set_ovr;
            end
        end
    end

    // Monitor: compares DUT outputs with the model away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("op_valid", 32'(bus.op_valid), 32'(m_full));
            check("busy", 32'(bus.busy), 32'(m_active));
            check("overrun", 32'(bus.overrun), 32'(m_ovr));
            if (m_full) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL scoreboard: got empty queue, expected a word (t=%0t)", $time);
                end else begin
                    if (bus.op_valid) begin
                        check("op", 32'(bus.op), 32'(sbq[0].word));
                        check("parity_err", 32'(bus.parity_err), 32'(sbq[0].perr));
                    end
                    if (bus.op_ready && !rst) void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic step(input logic s, input logic be, input logic d);
        bus.start  = s;
        bus.bit_en = be;
        bus.data   = d;
        case (rdy_mode)
            0:       bus.op_ready = 1'b0;
            1:       bus.op_ready = 1'b1;
            default: bus.op_ready = 1'($urandom_range(0, 1));
        endcase
        if (force_ready) bus.op_ready = 1'b1;
        case (clr_mode)
            0:       bus.clr_ovr = 1'b0;
            1:       bus.clr_ovr = 1'b1;
            default: bus.clr_ovr = ($urandom_range(0, 7) == 0);
        endcase
        @(posedge clk);
        #1;
    endtask

    // gap < 0 picks a random 0..3 idle cycles before each bit.
    task automatic send_frame(input logic [W-1:0] w, input logic pbit, input int gap,
                              input bit mid_start, input bit ready_last);
        int   g;
        logic b;
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < FRAME_BITS; i++) begin
            g = (gap < 0) ? $urandom_range(0, 3) : gap;
            for (int k = 0; k < g; k++) begin
                step(mid_start && (k == 0), 1'b0, 1'($urandom_range(0, 1)));
            end
            b = (i < W) ? w[W-1-i] : pbit;
            if (ready_last && (i == FRAME_BITS - 1)) force_ready = 1'b1;
            step(mid_start && (g == 0), 1'b1, b);
            force_ready = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.bit_en   = 1'b0;
        bus.data     = 1'b0;
        bus.op_ready = 1'b0;
        bus.clr_ovr  = 1'b0;

        // Reset, then strobes in idle must do nothing.
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check("op_after_reset", 32'(bus.op), 32'h0);
        check("parity_err_after_reset", 32'(bus.parity_err), 32'h0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'(k % 2), 1'b1);
        check("op_idle_strobes", 32'(bus.op), 32'h0);

        // Basic frame, held unconsumed, then drained.
        rdy_mode = 0;
        send_frame(8'hA5, 1'b0, 0, 1'b0, 1'b0);
        idle(3);
        rdy_mode = 1;
        idle(2);

        // Gapped strobes with ignored mid-frame starts, consumer always ready.
        send_frame(8'h3C, 1'b0, 2, 1'b1, 1'b0);
        idle(3);

        // Overrun: second word dropped, clear, drain the first.
        rdy_mode = 0;
        send_frame(8'h11, 1'b0, 0, 1'b0, 1'b0);
        idle(1);
        send_frame(8'h22, 1'b0, 0, 1'b0, 1'b0);
        idle(2);
        clr_mode = 1;
        idle(1);
        clr_mode = 0;
        rdy_mode = 1;
        idle(2);

        // Ready on the completion cycle replaces the word without overrun.
        rdy_mode = 0;
        send_frame(8'h11, 1'b0, 0, 1'b0, 1'b0);
        idle(1);
        send_frame(8'h22, 1'b0, 1, 1'b0, 1'b1);
        idle(2);
        rdy_mode = 1;
        idle(2);

        // Reset in the middle of a frame, then a clean frame.
        rdy_mode = 0;
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("op_after_midframe_reset", 32'(bus.op), 32'h0);
        send_frame(8'h81, 1'b0, 0, 1'b0, 1'b0);
        idle(2);
        rdy_mode = 1;
        idle(2);

        // Parity bit good, then bad (parity_err stays 0 when the feature is absent).
        rdy_mode = 0;
        send_frame(8'hA5, 1'b0, 0, 1'b0, 1'b0);
        idle(2);
        rdy_mode = 1;
        idle(1);
        rdy_mode = 0;
        send_frame(8'hA5, 1'b1, 0, 1'b0, 1'b0);
        idle(2);
        rdy_mode = 1;
        idle(1);

        // Randomized traffic.
        rdy_mode = 2;
        clr_mode = 2;
        for (int f = 0; f < 150; f++) begin
            int n_idle;
            n_idle = $urandom_range(0, 3);
            for (int k = 0; k < n_idle; k++) begin
                step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            send_frame(W'($urandom), 1'($urandom_range(0, 1)), -1,
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        rdy_mode = 1;
        clr_mode = 1;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
